seq_multiplier_param: RTL and testbench

Parametrised shift-add sequential multiplier. It computes the exact 2*WIDTH-bit product of two WIDTH-bit operands in either two's-complement or unsigned mode, selected per operation. It adds a valid/ready handshake on input and output and a clock enable. It is the arithmetic-unit building block for datapaths that cannot afford a combinational array multiplier and need flow control around a multi-cycle operation.

---
 rtl/seq_multiplier_param_if.sv | 26 ++
 rtl/seq_multiplier_param.sv | 119 +++++++++++
 tb/tb_seq_multiplier_param.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_param_if.sv
// Operand/result handshake bundle for the sequential multiplier.
interface seq_multiplier_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;

    // Producer/consumer side: presents operands, accepts results.
    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/seq_multiplier_param.sv
// Shift-add sequential multiplier, signed or unsigned per operation,
// WIDTH iterations per product with valid/ready flow control and clock enable.
module seq_multiplier_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    seq_multiplier_param_if.slave  bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [PW-1:0]      mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [PW-1:0]      acc_q,       acc_d;
    logic               signed_q,    signed_d;
    logic [PW-1:0]      result_q,    result_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic [PW-1:0]      addend;
    logic [PW-1:0]      acc_nx;
    logic               last_iter;

    // Next-state, datapath step and registered output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        signed_d = signed_q;
        result_d = result_q;

        // The multiplier MSB carries weight -2^(W-1) in signed mode, so the
        // last partial product is subtracted rather than added.
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
        addend    = mplier_q[0] ? mcand_q : '0;
        acc_nx    = (signed_q && last_iter) ? (acc_q - addend) : (acc_q + addend);

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        mcand_d  = {{WIDTH{bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};
                        mplier_d = bus.b;
                        signed_d = bus.signed_mode;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d    = acc_nx;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_d = acc_nx;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            signed_q    <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            signed_q    <= signed_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param at WIDTH=32 and WIDTH=8.
module tb_seq_multiplier_param;
    logic clk;
    logic reset;
    logic en;

    int n_cmp;
    int n_err;

    seq_multiplier_param_if #(.WIDTH(32)) bus32 ();
    seq_multiplier_param_if #(.WIDTH(8))  bus8  ();

    seq_multiplier_param #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus32.slave)
    );

    seq_multiplier_param #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus8.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete WIDTH=32 transaction with out_ready held high.
    task automatic run32(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                         input logic sm, input logic [63:0] exp);
        int k;
        int cyc;
        k = 0;
        while (!bus32.in_ready && k < 50) begin tick(); k++; end
        chk({tag, "_rdy"}, 64'(bus32.in_ready), 64'd1);
        bus32.a = oa; bus32.b = ob; bus32.signed_mode = sm; bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        cyc = 0;
        while (!bus32.out_valid && cyc < 200) begin tick(); cyc++; end
        chk({tag, "_lat"}, 64'(cyc), 64'd32);
        chk({tag, "_res"}, bus32.result, exp);
        tick();
        chk({tag, "_idle"}, 64'(bus32.in_ready), 64'd1);
    endtask

    // One complete WIDTH=8 transaction with out_ready held high.
    task automatic run8(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                        input logic sm, input logic [15:0] exp);
        int cyc;
        chk({tag, "_rdy"}, 64'(bus8.in_ready), 64'd1);
        bus8.a = oa; bus8.b = ob; bus8.signed_mode = sm; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        cyc = 0;
        while (!bus8.out_valid && cyc < 100) begin tick(); cyc++; end
        chk({tag, "_lat"}, 64'(cyc), 64'd8);
        chk({tag, "_res"}, 64'(bus8.result), 64'(exp));
        tick();
    endtask

    initial begin
        int cyc;
        clk = 1'b0;
        n_cmp = 0;
        n_err = 0;
        en = 1'b1;
        reset = 1'b0;
        bus32.in_valid = 1'b1; bus32.a = 32'd5; bus32.b = 32'd5;
        bus32.signed_mode = 1'b0; bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b1; bus8.a = 8'd5; bus8.b = 8'd5;
        bus8.signed_mode = 1'b0; bus8.out_ready = 1'b1;

        // Reset held two cycles with in_valid asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_in_ready",  64'(bus32.in_ready),  64'd1);
            chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
            chk("rst_busy",      64'(bus32.busy),      64'd0);
            chk("rst_result",    bus32.result,         64'd0);
        end
        chk("rst8_busy",   64'(bus8.busy),   64'd0);
        chk("rst8_result", 64'(bus8.result), 64'd0);
        reset = 1'b1;
        bus32.in_valid = 1'b0;
        bus8.in_valid  = 1'b0;
        tick();
        chk("post_rst_busy", 64'(bus32.busy), 64'd0);

        // Unsigned and mode distinction.
        run32("u_basic", 32'd553524, 32'd840, 1'b0, 64'd464960160);
        run32("s_mix",   32'd553524, 32'hFFFFFEFD, 1'b1, -64'sd143362716);
        run32("u_mix",   32'd553524, 32'hFFFFFEFD, 1'b0, 64'h00087233F7747564);

        // Extremes.
        run32("s_m1m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1);
        run32("u_maxsq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
        run32("s_minsq", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
        run8("w8_s_minsq", 8'h80, 8'h80, 1'b1, 16'h4000);
        run8("w8_u_maxsq", 8'hFF, 8'hFF, 1'b0, 16'hFE01);

        // Result held while out_ready is low.
        bus32.out_ready = 1'b0;
        bus32.a = 32'd3; bus32.b = 32'd4; bus32.signed_mode = 1'b0; bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        cyc = 0;
        while (!bus32.out_valid && cyc < 200) begin tick(); cyc++; end
        chk("hold_lat", 64'(cyc), 64'd32);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", 64'(bus32.out_valid), 64'd1);
            chk("hold_result",    bus32.result,         64'd12);
            chk("hold_in_ready",  64'(bus32.in_ready),  64'd0);
        end
        bus32.out_ready = 1'b1;
        tick();
        chk("xfer_in_ready",  64'(bus32.in_ready),  64'd1);
        chk("xfer_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("xfer_result",    bus32.result,         64'd12);

        // en dropped for three edges mid-run stretches latency by three.
        bus32.a = 32'd100; bus32.b = 32'd200; bus32.signed_mode = 1'b0; bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        cyc = 0;
        while (!bus32.out_valid && cyc < 200) begin
            tick();
            cyc++;
            en = (cyc < 10 || cyc >= 13);
        end
        en = 1'b1;
        chk("en_lat", 64'(cyc), 64'd35);
        chk("en_res", bus32.result, 64'd20000);
        tick();

        // Operand changes during RUN are ignored.
        bus32.a = 32'd1234; bus32.b = 32'd5678; bus32.signed_mode = 1'b0; bus32.in_valid = 1'b1;
        tick();
        cyc = 0;
        while (!bus32.out_valid && cyc < 200) begin
            bus32.a = $urandom; bus32.b = $urandom; bus32.signed_mode = cyc[0];
            tick();
            cyc++;
        end
        bus32.in_valid = 1'b0;
        chk("chg_lat", 64'(cyc), 64'd32);
        chk("chg_res", bus32.result, 64'd7006652);
        tick();

        // Reset at iteration 10 discards the operation and clears result.
        bus32.a = 32'd9; bus32.b = 32'd9; bus32.signed_mode = 1'b1; bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_busy_before", 64'(bus32.busy), 64'd1);
        reset = 1'b0;
        tick();
        chk("mid_in_ready",  64'(bus32.in_ready),  64'd1);
        chk("mid_busy",      64'(bus32.busy),      64'd0);
        chk("mid_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("mid_result",    bus32.result,         64'd0);
        reset = 1'b1;
        tick();
        run32("after_rst", 32'd7, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
